// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage with PC, writable instruction memory and UART program-load mode
//
// Purpose:
//   Holds the PC and a word-addressed instruction memory, presents the current
//   instruction to the decoder, and computes the next PC from the decoder's
//   jump/branch controls. A small mode machine (RUN/LOAD/FLUSH/HALT) lets the
//   UART program loader rewrite memory while fetch is suspended.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   stall                        hold PC and ignore decoder controls this cycle
//   Addr_result                  branch target from the ALU
//   Read_data_1                  rs value, used as the jr target
//   Zero                         ALU equality flag
//   Branch, nBranch, Jmp, Jal, Jr decoder control outputs
//   upg_en, upg_wen, upg_adr,
//   upg_dat, upg_done            program-load request, write port and completion flag
//   Instruction, Opcode,
//   Function_opcode              current instruction and its decode fields
//   PC, branch_base_addr,
//   link_addr                    current PC, PC+4, and PC+4 gated by Jal
//   fetch_valid                  Instruction is executable this cycle
//   addr_err                     sticky illegal-target flag

module ifetch_unit #(
    parameter int          ROM_AW   = 14,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic [31:0]       Addr_result,
    input  logic [31:0]       Read_data_1,
    input  logic              Zero,
    input  logic              Branch,
    input  logic              nBranch,
    input  logic              Jmp,
    input  logic              Jal,
    input  logic              Jr,
    input  logic              upg_en,
    input  logic              upg_wen,
    input  logic [ROM_AW-1:0] upg_adr,
    input  logic [31:0]       upg_dat,
    input  logic              upg_done,
    output logic [31:0]       Instruction,
    output logic [5:0]        Opcode,
    output logic [5:0]        Function_opcode,
    output logic [31:0]       PC,
    output logic [31:0]       branch_base_addr,
    output logic [31:0]       link_addr,
    output logic              fetch_valid,
    output logic              addr_err
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] mem [1 << ROM_AW];

    logic              run;
    logic [ROM_AW-1:0] rom_idx;
    logic [31:0]       pc4;
    logic [31:0]       next_pc;
    logic              branch_taken;
    logic              jr_misaligned;
    logic              target_out_of_range;

    assign run     = (state_q == ST_RUN);
    assign rom_idx = pc_q[ROM_AW+1:2];
    assign pc4     = pc_q + 32'd4;

    // Asynchronous read; a nop is shown whenever fetch is suspended.
    assign Instruction     = run ? mem[rom_idx] : 32'h0;
    assign Opcode          = Instruction[31:26];
    assign Function_opcode = Instruction[5:0];

    assign PC               = pc_q;
    assign branch_base_addr = run ? pc4 : 32'h0;
    assign link_addr        = (run && Jal) ? pc4 : 32'h0;
    assign fetch_valid      = run;
    assign addr_err         = addr_err_q;

    assign branch_taken  = (Branch & Zero) | (nBranch & ~Zero);
    assign jr_misaligned = Jr && (Read_data_1[1:0] != 2'b00);

    always_comb begin
        next_pc = pc4;
        if (Jr) begin
            next_pc = {Read_data_1[31:2], 2'b00};
        end else if (Jmp || Jal) begin
            next_pc = {pc4[31:28], Instruction[25:0], 2'b00};
        end else if (branch_taken) begin
            next_pc = Addr_result;
        end
    end

    // Any bit above the memory's byte-address range means the target lies
    // outside instruction memory.
    assign target_out_of_range = ((next_pc >> (ROM_AW + 2)) != 32'd0);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_err_d = addr_err_q;
        if (upg_en) begin
            // A load request overrides stall and any control-flow change.
            state_d = ST_LOAD;
            pc_d    = RESET_PC;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!stall) begin
                        pc_d = next_pc;
                        if (jr_misaligned || target_out_of_range) begin
                            addr_err_d = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    state_d = upg_done ? ST_FLUSH : ST_HALT;
                end
                ST_FLUSH: begin
                    state_d = ST_RUN;
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Memory is not cleared by reset, but a write is suppressed while reset is high.
    always_ff @(posedge clock) begin
        if (!reset && (state_q == ST_LOAD) && upg_wen) begin
            mem[upg_adr] <= upg_dat;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit with a behavioural reference model

module tb_ifetch_unit;

    localparam int AW    = 6;
    localparam int WORDS = 1 << AW;

    localparam int M_RUN   = 0;
    localparam int M_LOAD  = 1;
    localparam int M_FLUSH = 2;
    localparam int M_HALT  = 3;

    logic          clock = 1'b0;
    logic          reset, stall, Zero, Branch, nBranch, Jmp, Jal, Jr;
    logic [31:0]   Addr_result, Read_data_1, upg_dat;
    logic          upg_en, upg_wen, upg_done;
    logic [AW-1:0] upg_adr;
    logic [31:0]   Instruction, PC, branch_base_addr, link_addr;
    logic [5:0]    Opcode, Function_opcode;
    logic          fetch_valid, addr_err;

    always #5 clock = ~clock;

    ifetch_unit #(.ROM_AW(AW), .RESET_PC(32'h0)) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .Addr_result     (Addr_result),
        .Read_data_1     (Read_data_1),
        .Zero            (Zero),
        .Branch          (Branch),
        .nBranch         (nBranch),
        .Jmp             (Jmp),
        .Jal             (Jal),
        .Jr              (Jr),
        .upg_en          (upg_en),
        .upg_wen         (upg_wen),
        .upg_adr         (upg_adr),
        .upg_dat         (upg_dat),
        .upg_done        (upg_done),
        .Instruction     (Instruction),
        .Opcode          (Opcode),
        .Function_opcode (Function_opcode),
        .PC              (PC),
        .branch_base_addr(branch_base_addr),
        .link_addr       (link_addr),
        .fetch_valid     (fetch_valid),
        .addr_err        (addr_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    // Reference model state
    logic [31:0] m_mem   [WORDS];
    bit          m_known [WORDS];
    logic [31:0] m_pc;
    int          m_st;
    bit          m_err;
    bit          m_valid = 0;

    logic [31:0] prog [WORDS];

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % WORDS);
    endfunction

    function automatic logic [31:0] m_instr();
        if (m_st != M_RUN) return 32'h0;
        return m_mem[widx(m_pc)];
    endfunction

    task automatic compare_outputs();
        logic [31:0] ei;
        bit run;
        run = (m_st == M_RUN);
        ei  = m_instr();
        check("pc", PC, m_pc);
        check("fv", 32'(fetch_valid), 32'(run));
        check("err", 32'(addr_err), 32'(m_err));
        check("bba", branch_base_addr, run ? m_pc + 32'd4 : 32'h0);
        check("link", link_addr, (run && Jal) ? m_pc + 32'd4 : 32'h0);
        if (!run || m_known[widx(m_pc)]) begin
            check("instr", Instruction, ei);
            check("opcode", 32'(Opcode), ei >> 26);
            check("funct", 32'(Function_opcode), ei & 32'h3f);
        end
    endtask

    task automatic model_update();
        logic [31:0] pc4, tgt, ins;
        if (reset) begin
            m_pc = 32'h0; m_st = M_RUN; m_err = 0; m_valid = 1;
            return;
        end
        if (m_st == M_LOAD && upg_wen) begin
            m_mem[upg_adr]   = upg_dat;
            m_known[upg_adr] = 1;
        end
        if (upg_en) begin
            m_st = M_LOAD; m_pc = 32'h0;
        end else if (m_st == M_LOAD) begin
            m_st = upg_done ? M_FLUSH : M_HALT;
        end else if (m_st == M_FLUSH) begin
            m_st = M_RUN;
        end else if (m_st == M_RUN && !stall) begin
            pc4 = m_pc + 32'd4;
            ins = m_instr();
            if (Jr) begin
                tgt = Read_data_1 & ~32'h3;
                if ((Read_data_1 & 32'h3) != 0) m_err = 1;
            end else if (Jmp || Jal) begin
                tgt = (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
            end else if ((Branch && Zero) || (nBranch && !Zero)) begin
                tgt = Addr_result;
            end else begin
                tgt = pc4;
            end
            if (tgt >= 32'(WORDS * 4)) m_err = 1;
            m_pc = tgt;
        end
    endtask

    // Inputs are set at posedge+1; outputs are compared near the negedge.
    task automatic tick();
        #4;
        if (m_valid) compare_outputs();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic clr();
        reset = 0; stall = 0; Zero = 0; Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jr = 0;
        Addr_result = 0; Read_data_1 = 0; upg_en = 0; upg_wen = 0; upg_adr = 0;
        upg_dat = 0; upg_done = 0;
    endtask

    task automatic load_prog(input bit done);
        clr(); upg_en = 1; tick();
        for (int i = 0; i < WORDS; i++) begin
            upg_wen = 1; upg_adr = AW'(i); upg_dat = prog[i]; tick();
        end
        upg_en = 0; upg_wen = 0; upg_done = done; tick();
        clr();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[25:0] = 26'($urandom_range(0, WORDS - 1));
        return w;
    endfunction

    logic [31:0] hold_pc, hold_ins;

    initial begin
        for (int i = 0; i < WORDS; i++) m_known[i] = 0;
        m_pc = 0; m_st = M_RUN; m_err = 0;
        clr();
        reset = 1;
        tick(); tick();
        clr();
        check("rst_pc", PC, 32'h0);
        check("rst_fv", 32'(fetch_valid), 32'h1);
        check("rst_err", 32'(addr_err), 32'h0);

        // Directed program: A..D at 0..3, a jal with target field 0x10 at 0x20
        for (int i = 0; i < WORDS; i++) prog[i] = rand_word();
        prog[0] = 32'hA000_0001; prog[1] = 32'hB000_0002;
        prog[2] = 32'hC000_0003; prog[3] = 32'hD000_0004;
        prog[8] = {6'h03, 26'h10};
        load_prog(1);
        check("flush_fv", 32'(fetch_valid), 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("seq_pc", PC, 32'(i * 4));
            check("seq_instr", Instruction, prog[i]);
            tick();
        end

        Branch = 1; Zero = 1; Addr_result = 32'h40; tick();
        check("beq_taken", PC, 32'h40);
        clr(); Jr = 1; Read_data_1 = 32'h10; tick();
        clr(); nBranch = 1; Zero = 1; Addr_result = 32'h40; tick();
        check("bne_not_taken", PC, 32'h14);
        clr(); Jr = 1; Read_data_1 = 32'h10; tick();
        clr(); nBranch = 1; Zero = 0; Addr_result = 32'h40; tick();
        check("bne_taken", PC, 32'h40);
        clr(); Jr = 1; Read_data_1 = 32'h20; tick();
        clr(); Jal = 1; #1;
        check("jal_link", link_addr, 32'h24);
        tick();
        check("jal_pc", PC, 32'h40);
        clr(); Jr = 1; Read_data_1 = 32'h24; tick();
        check("jr_pc", PC, 32'h24);
        check("jr_err", 32'(addr_err), 32'h0);
        clr(); Jr = 1; Jmp = 1; Read_data_1 = 32'h08; tick();
        check("jr_over_jmp", PC, 32'h08);

        clr(); stall = 1; Jmp = 1; hold_pc = PC; hold_ins = Instruction;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", PC, hold_pc);
            check("stall_instr", Instruction, hold_ins);
        end

        clr(); Jr = 1; Read_data_1 = 32'h33; tick();
        check("jr_mis_pc", PC, 32'h30);
        check("jr_mis_err", 32'(addr_err), 32'h1);
        clr();
        for (int i = 0; i < 3; i++) tick();
        check("err_sticky", 32'(addr_err), 32'h1);

        upg_en = 1; Jmp = 1; tick();
        check("load_pc", PC, 32'h0);
        check("load_fv", 32'(fetch_valid), 32'h0);
        clr(); upg_done = 0; tick();
        clr();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_fv", 32'(fetch_valid), 32'h0);
            check("halt_pc", PC, 32'h0);
        end
        load_prog(1);
        tick();
        check("resume_fv", 32'(fetch_valid), 32'h1);
        check("resume_pc", PC, 32'h0);
        upg_en = 1; tick(); tick();
        clr(); reset = 1; tick();
        clr();
        check("rst_load_fv", 32'(fetch_valid), 32'h1);
        check("rst_load_pc", PC, 32'h0);
        check("rst_load_err", 32'(addr_err), 32'h0);

        // Randomized phase against the model
        for (int i = 0; i < WORDS; i++) prog[i] = rand_word();
        load_prog(1);
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 99) == 0);
            stall       = ($urandom_range(0, 7) == 0);
            Jr          = ($urandom_range(0, 5) == 0);
            Jmp         = ($urandom_range(0, 5) == 0);
            Jal         = ($urandom_range(0, 5) == 0);
            Branch      = ($urandom_range(0, 4) == 0);
            nBranch     = ($urandom_range(0, 4) == 0);
            Zero        = 1'($urandom_range(0, 1));
            Addr_result = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, WORDS * 4 - 1));
            Read_data_1 = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, WORDS * 4 - 1));
            upg_en      = ($urandom_range(0, 39) == 0);
            upg_done    = ($urandom_range(0, 3) != 0);
            upg_wen     = 1'($urandom_range(0, 1));
            upg_adr     = AW'($urandom_range(0, WORDS - 1));
            upg_dat     = rand_word();
            tick();
        end
        clr();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage of the single-cycle MIPS core, directly upstream of the main control decoder.
- Holds the PC and an internal writable instruction memory, and presents Instruction, Opcode and Function_opcode to the decoder.
- Computes the next PC from the decoder's Jr/Jmp/Jal/Branch/nBranch outputs, the ALU Zero flag and the branch target.
- Provides a UART program-load (upg) mode with a small mode state machine.

Parameters:
- ROM_AW, 14, word-address width of instruction memory (2^ROM_AW 32-bit words)
- RESET_PC, 32'h0000_0000, PC value after reset and after a completed load

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC; the decoder's control inputs are ignored this cycle
- Addr_result  in  32  branch target from the ALU
- Read_data_1  in  32  rs value, used as the jr target
- Zero  in  1  ALU equality flag
- Branch, nBranch, Jmp, Jal, Jr  in  1 each  decoder control outputs
- upg_en  in  1  program-load mode request
- upg_wen  in  1  instruction memory write strobe (honoured only in LOAD)
- upg_adr  in  ROM_AW  word address for the write
- upg_dat  in  32  write data
- upg_done  in  1  load-complete flag, sampled when upg_en falls
- Instruction  out  32  current instruction
- Opcode  out  6  Instruction[31:26]
- Function_opcode  out  6  Instruction[5:0]
- PC  out  32  current PC
- branch_base_addr  out  32  PC+4
- link_addr  out  32  PC+4 while Jal is high, else 0
- fetch_valid  out  1  Instruction is executable this cycle
- addr_err  out  1  sticky illegal-target flag

Behaviour:
- Reset (synchronous, active-high) sets:
  - PC=RESET_PC
  - state=RUN
  - addr_err=0
  - Memory contents are not reset.
- Reset dominates every other input, including upg_en.
- Mode states: RUN, LOAD, FLUSH, HALT.
  - Any state goes to LOAD when upg_en=1.
  - LOAD goes to FLUSH when upg_en=0 and upg_done=1.
  - LOAD goes to HALT when upg_en=0 and upg_done=0 (aborted load).
  - FLUSH goes to RUN after exactly one cycle.
  - HALT is left only by reset or by upg_en=1.
- Outputs by state:
  - RUN: fetch_valid=1 and Instruction=mem[PC[ROM_AW+1:2]] (asynchronous read).
  - LOAD, FLUSH and HALT: fetch_valid=0, Instruction=32'h0 (nop), and Opcode/Function_opcode follow Instruction.
- PC handling outside RUN:
  - Entering LOAD forces PC=RESET_PC on that edge; PC stays there through LOAD.
  - In FLUSH and HALT, PC holds.
- Memory write: in LOAD with upg_wen=1, mem[upg_adr] is written with upg_dat on the rising edge. upg_wen is ignored in every other state.
- Next PC applies in RUN with stall=0. Priority, highest first:
  1. Jr: {Read_data_1[31:2],2'b00}
  2. Jmp or Jal: {PC4[31:28],Instruction[25:0],2'b00}, where PC4=PC+4
  3. Taken branch, i.e. (Branch&Zero)|(nBranch&~Zero): Addr_result
  4. Otherwise: PC4
- PC arithmetic is mod 2^32. The memory index wraps modulo 2^ROM_AW.
- addr_err is set, sticky until reset, when an applied Jr target has Read_data_1[1:0]!=0. The PC is still loaded with the aligned target.
- addr_err is also set when any applied next PC has bits [31:ROM_AW+2] nonzero.
- stall=1 in RUN: PC holds, Instruction is unchanged, no addr_err update.
- upg_en=1 in the same cycle as stall or any jump/branch: LOAD wins.
- branch_base_addr and link_addr are combinational from the current PC. Both read 0 outside RUN.

Test Plan:
- Reset, then sequential fetch: load mem[0..3]=A,B,C,D via upg, finish with upg_done=1. Required: one FLUSH cycle with fetch_valid=0, then PC=0,4,8,12 on successive cycles with Instruction=A,B,C,D.
- Branch pair at PC=0x10, Addr_result=0x40:
  - Branch=1, Zero=1: next PC=0x40.
  - nBranch=1, Zero=1: next PC=0x14.
  - nBranch=1, Zero=0: next PC=0x40.
- Jal at PC=0x20 with Instruction[25:0]=26'h10. Required: link_addr=0x24 that cycle, next PC=0x40. Then Jr=1 with Read_data_1=0x24: next PC=0x24, addr_err=0.
- Jr with Read_data_1=0x33. Required: next PC=0x30, addr_err=1, and addr_err stays 1 until reset.
- Priority and stall:
  - Jr=1 and Jmp=1 together: the Jr target is taken.
  - stall=1 for 3 cycles: PC and Instruction are constant.
  - upg_en=1 coinciding with Jmp: state=LOAD, PC=0.
- Aborted load: upg_en falls with upg_done=0. Required: HALT, fetch_valid=0, PC frozen. A new upg_en with a good load then resumes RUN at 0; reset mid-LOAD returns to RUN at PC=0.
